// File: rtl/sub_bytes_engine.sv
// Sequential AES SubBytes engine: substitutes LANES bytes of a 128-bit state per cycle.
// Define SUBBYTES_FWD_EN to add forward S-box tables selected by in_inv; otherwise inverse only.
module sub_bytes_engine #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam int unsigned STEPS = 16 / LANES;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // GF(2^8) arithmetic, AES polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

`ifdef SUBBYTES_FWD_EN
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic mode_q, mode_d;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [127:0]  work_q, work_d;
    logic [127:0]  work_sub;
    logic          out_valid_d;
    logic [127:0]  out_state_d;
    int unsigned   pos;

    // Substitute the current group of LANES bytes in place
    always_comb begin
        work_sub = work_q;
        pos      = 0;
        for (int unsigned l = 0; l < LANES; l++) begin
            pos = 127 - 8 * (32'(cnt_q) * LANES + l);
`ifdef SUBBYTES_FWD_EN
            work_sub[pos -: 8] = mode_q ? inv_sbox(work_q[pos -: 8]) : fwd_sbox(work_q[pos -: 8]);
`else
            work_sub[pos -: 8] = inv_sbox(work_q[pos -: 8]);
`endif
        end
    end

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        out_valid_d = out_valid;
        out_state_d = out_state;
`ifdef SUBBYTES_FWD_EN
        mode_d      = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef SUBBYTES_FWD_EN
                    mode_d  = in_inv;
`endif
                end
            end
            BUSY: begin
                work_d = work_sub;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d       = '0;
                    out_state_d = work_sub;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    // Handoff and new accept share one edge
                    if (in_valid) begin
                        work_d  = in_state;
                        cnt_d   = '0;
                        state_d = BUSY;
`ifdef SUBBYTES_FWD_EN
                        mode_d  = in_inv;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            out_valid <= 1'b0;
            out_state <= '0;
`ifdef SUBBYTES_FWD_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            out_valid <= out_valid_d;
            out_state <= out_state_d;
`ifdef SUBBYTES_FWD_EN
            mode_q    <= mode_d;
`endif
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed, table-driven bench for sub_bytes_engine (LANES=4 main instance plus a LANES sweep).
module tb_sub_bytes_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    logic         sw_valid     [4];
    logic         sw_in_ready  [4];
    logic         sw_out_valid [4];
    logic [127:0] sw_out_state [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sub_bytes_engine #(.LANES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        sub_bytes_engine #(.LANES(L)) u_sw (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sw_valid[g]),
            .in_ready  (sw_in_ready[g]),
            .in_state  (128'h0),
            .in_inv    (1'b1),
            .out_valid (sw_out_valid[g]),
            .out_ready (1'b1),
            .out_state (sw_out_state[g])
        );
    end

    typedef struct {
        string        name;
        logic [127:0] st;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] V1_IN  = 128'h002356A3_4E19FFCC_DF000000_00000000;
    localparam logic [127:0] V1_OUT = 128'h5232B971_B68E7D27_EF525252_52525252;
    localparam logic [127:0] ALL52  = {16{8'h52}};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns edges from accept to out_valid
    task automatic send(input logic [127:0] st, input logic inv, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_accept", 128'(in_ready), 128'(1));
        in_state = st;
        in_inv   = inv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_inv   = ~inv;
        in_state = {4{$urandom}};
        chk("in_ready_busy", 128'(in_ready), 128'(0));
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    vec_t vecs[6];
    int   lat;
    logic saw_valid;

    initial begin
        int exp_lat[4];
        exp_lat = '{16, 8, 2, 1};

        vecs[0] = '{"inv_mixed", V1_IN, 1'b1, V1_OUT};
        vecs[1] = '{"inv_zero", 128'h0, 1'b1, ALL52};
        vecs[2] = '{"inv_ff", {16{8'hFF}}, 1'b1, {16{8'h7D}}};
        vecs[4] = '{"inv_roundtrip", {8'h00, 8'hED, {14{8'h7C}}}, 1'b1, {8'h52, 8'h53, {14{8'h01}}}};
`ifdef SUBBYTES_FWD_EN
        vecs[3] = '{"fwd_zero", 128'h0, 1'b0, {16{8'h63}}};
        vecs[5] = '{"fwd_mixed", {8'h52, 8'h53, {14{8'h01}}}, 1'b0, {8'h00, 8'hED, {14{8'h7C}}}};
`else
        vecs[3] = '{"inv_forced_zero", 128'h0, 1'b0, ALL52};
        vecs[5] = '{"inv_forced_mixed", {8'h52, 8'h53, {14{8'h01}}}, 1'b0, {8'h48, 8'h50, {14{8'h09}}}};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_inv    = 1'b0;
        out_ready = 1'b1;
        for (int g = 0; g < 4; g++) sw_valid[g] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state held while idle
        for (int c = 0; c < 6; c++) begin
            chk("reset_out_valid", 128'(out_valid), 128'(0));
            chk("reset_out_state", out_state, 128'h0);
            chk("reset_in_ready", 128'(in_ready), 128'(1));
            @(negedge clk);
        end

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].st, vecs[i].inv, lat);
            chk({vecs[i].name, "_latency"}, 128'(lat), 128'(4));
            chk({vecs[i].name, "_data"}, out_state, vecs[i].exp);
        end
        @(negedge clk);

        // Backpressure in DONE, then handoff plus accept on one edge
        out_ready = 1'b0;
        send(V1_IN, 1'b1, lat);
        chk("bp_latency", 128'(lat), 128'(4));
        for (int c = 0; c < 10; c++) begin
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_out_state", out_state, V1_OUT);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = 128'h0;
        in_inv    = 1'b1;
        #1;
        chk("handoff_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("handoff_out_valid_low", 128'(out_valid), 128'(0));
        chk("handoff_out_state_kept", out_state, V1_OUT);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("handoff_next_latency", 128'(lat), 128'(4));
        chk("handoff_next_data", out_state, ALL52);
        @(negedge clk);

        // Reset during the second BUSY cycle discards the transaction
        in_state = {16{8'hFF}};
        in_inv   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        chk("midbusy_rst_no_valid", 128'(saw_valid), 128'(0));
        chk("midbusy_rst_out_state", out_state, 128'h0);
        send(V1_IN, 1'b1, lat);
        chk("after_rst_latency", 128'(lat), 128'(4));
        chk("after_rst_data", out_state, V1_OUT);
        @(negedge clk);

        // LANES sweep with the all-zero inverse vector
        for (int g = 0; g < 4; g++) begin
            chk("sweep_in_ready", 128'(sw_in_ready[g]), 128'(1));
            sw_valid[g] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            sw_valid[g] = 1'b0;
            lat = 0;
            while (!sw_out_valid[g] && lat < 40) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            chk($sformatf("sweep%0d_latency", g), 128'(lat), 128'(exp_lat[g]));
            chk($sformatf("sweep%0d_data", g), sw_out_state[g], ALL52);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
